// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regs
// Description : APB completer exposing eight 32-bit registers in a 32-byte
//               window at BASE_ADDR. REG0..REG6 are read/write; REG7 is a
//               read-only count of completed transfers (wraps at 2^32).
//               Each access is stretched by WAIT_CYCLES wait states.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : BASE_ADDR   - 32-byte-aligned base of the register window
//               WAIT_CYCLES - wait states per access, 0..15
// Ports       : hclk    in   clock, all state changes on rising edge
//               hreset  in   asynchronous active-high reset
//               psel    in   slave select
//               penable in   access-phase indicator
//               pwrite  in   1 = write, 0 = read
//               paddr   in   [31:0] byte address
//               pwdata  in   [31:0] write data
//               prdata  out  [31:0] read data (zero unless a read completes)
//               pready  out  transfer-complete indicator
//               pslverr out  transfer error indicator
// Options     : define APB_SLV_ERR_EN to report out-of-range accesses and
//               writes to REG7 on pslverr; otherwise pslverr is tied low.
// ============================================================================
module apb_slave_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic       c_st_idle   = 1'b0;
    localparam logic       c_st_access = 1'b1;
    localparam logic [3:0] c_wait_init = WAIT_CYCLES[3:0];
    localparam int         c_num_rw    = 7;

    logic        r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_regs [c_num_rw];
    logic [31:0] r_count;

    logic        w_in_range;
    logic [2:0]  w_idx;
    logic        w_ro_hit;
    logic        w_ready;
    logic        w_complete;
    logic        w_wr_commit;
    logic [31:0] w_sel_data;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_in_range = (paddr[31:5] == BASE_ADDR[31:5]) && (paddr[1:0] == 2'b00);
    assign w_idx      = paddr[4:2];
    assign w_ro_hit   = (w_idx == 3'd7);

    // pready is purely a decode of registered state, so it is glitch-free
    // with respect to the APB inputs.
    assign w_ready     = (r_state == c_st_access) && (r_wait_cnt == 4'd0);
    assign w_complete  = w_ready && psel && penable;
    assign w_wr_commit = w_complete && pwrite && w_in_range && !w_ro_hit;

    // ------------------------------------------------------------------
    // Transfer FSM with wait-state counter
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= c_st_idle;
            r_wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (psel && !penable) begin
                        r_state    <= c_st_access;
                        r_wait_cnt <= c_wait_init;
                    end
                end
                c_st_access: begin
                    if (!psel) begin
                        // Requester abandoned the transfer: nothing commits.
                        r_state <= c_st_idle;
                    end else if (penable) begin
                        if (r_wait_cnt != 4'd0) begin
                            r_wait_cnt <= r_wait_cnt - 4'd1;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read/write registers REG0..REG6
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_num_rw; gi++) begin : g_regs
            always_ff @(posedge hclk or posedge hreset) begin
                if (hreset) begin
                    r_regs[gi] <= 32'h0;
                end else if (w_wr_commit && (w_idx == 3'(gi))) begin
                    r_regs[gi] <= pwdata;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // REG7: completed-transfer counter. Error transfers count too; the
    // natural 32-bit overflow provides the wrap to zero.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_count <= 32'h0;
        end else if (w_complete) begin
            r_count <= r_count + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read path. Reading REG7 returns the pre-increment value because the
    // counter only updates on the completing edge itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_data = r_count;
        for (int i = 0; i < c_num_rw; i++) begin
            if (w_idx == 3'(i)) begin
                w_sel_data = r_regs[i];
            end
        end
    end

    assign prdata = (w_ready && !pwrite && w_in_range) ? w_sel_data : 32'h0;
    assign pready = w_ready;

`ifdef APB_SLV_ERR_EN
    // Error only in the completing cycle, which also keeps pslverr low
    // whenever pready is low.
    assign pslverr = w_complete && (!w_in_range || (pwrite && w_ro_hit));
`else
    assign pslverr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000; 32-byte-aligned base of the register window.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1; wait states inserted per access, legal range 0..15.
REQ-003 SHALL have port hclk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port hreset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port psel  input  1  slave select from the APB requester.
REQ-006 SHALL have port penable  input  1  access-phase indicator.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port paddr  input  32  byte address.
REQ-009 SHALL have port pwdata  input  32  write data.
REQ-010 SHALL have port prdata  output  32  read data.
REQ-011 SHALL have port pready  output  1  transfer-complete indicator.
REQ-012 SHALL have port pslverr  output  1  transfer error indicator.

Function
REQ-013 SHALL implement eight 32-bit registers selected by paddr[4:2]: REG0..REG6 read/write; REG7 read-only count of completed transfers.
REQ-014 SHALL treat an address as in range when paddr[31:5] equals BASE_ADDR[31:5] and paddr[1:0] is 2'b00.
REQ-015 SHALL use FSM states IDLE and ACCESS, plus a 4-bit wait counter.
REQ-016 IDLE: on psel=1 and penable=0 (setup phase), load the counter with WAIT_CYCLES and move to ACCESS; otherwise stay in IDLE.
REQ-017 ACCESS: pready SHALL be 1 exactly when the counter is 0; while the counter is non-zero and psel=penable=1, decrement it by 1 per cycle.
REQ-018 ACCESS: a transfer SHALL complete on the edge where psel=penable=pready=1; the FSM then returns to IDLE.
REQ-019 Total latency from the setup cycle to completion SHALL be 1+WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0, pready is high in the first penable cycle.
REQ-020 Writes: an in-range write to REG0..REG6 SHALL update that register with pwdata on the completing edge, and no earlier.
REQ-021 Writes to REG7 and out-of-range writes SHALL leave all registers unchanged.
REQ-022 Reads: prdata SHALL show the selected register, combinationally, only while in ACCESS with pready=1 and pwrite=0; otherwise prdata SHALL be 32'h0.
REQ-023 Out-of-range reads SHALL return 32'h0.
REQ-024 REG7 SHALL increment by 1 on every completing edge, including error transfers, and wrap from 32'hFFFF_FFFF to 0.
REQ-025 A read of REG7 SHALL return the value from before that transfer's own increment.
REQ-026 If psel drops while in ACCESS (aborted transfer), the FSM SHALL return to IDLE with no register write and no REG7 increment.
REQ-027 pready and pslverr SHALL be 0 in IDLE.
REQ-028 pslverr SHALL be 0 in every cycle in which pready is 0.
REQ-029 A new setup phase in the cycle after completion SHALL be accepted with no dead cycle (back-to-back transfers).

Reset
REQ-030 While hreset=1, asynchronously: state=IDLE, counter=0, REG0..REG7=32'h0, pready=0, pslverr=0, prdata=32'h0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no write committed.
REQ-032 After release, the first rising edge SHALL be able to accept a setup phase.

Configuration
REQ-033 Macro APB_SLV_ERR_EN defined: pslverr=1 in the completing cycle for an out-of-range address or a write to REG7; otherwise 0.
REQ-034 Macro APB_SLV_ERR_EN undefined: pslverr SHALL be tied 0; the silent-ignore and read-zero behaviour of REQ-021 and REQ-023 is unchanged.

Verification
REQ-035 WAIT_CYCLES=1: write 32'hDEAD_BEEF to 32'h8000_0004, then read it back -> each access completes 3 cycles after setup; read returns 32'hDEAD_BEEF; REG7=2.
REQ-036 WAIT_CYCLES=0: back-to-back writes to REG0..REG6 with data 32'h1..32'h7, then reads -> pready high in the first penable cycle; reads return 32'h1..32'h7.
REQ-037 With APB_SLV_ERR_EN: write to 32'h8000_001C, then read 32'h9000_0000 -> pslverr=1 on both; REG7 not overwritten; read returns 32'h0. Without the macro: pslverr=0 on both.
REQ-038 Drop psel after 1 cycle of a 3-wait-state write to REG2 -> REG2 stays 0, REG7 unchanged, next transfer completes normally.
REQ-039 Assert hreset during the wait phase of a write of 32'h5A5A_5A5A to REG1 -> pready=0 immediately; REG1 and REG7 read 32'h0 after release.
REQ-040 Force REG7 to 32'hFFFF_FFFF via 2^32 - 1 completions (or a bench force), then one more transfer -> REG7=32'h0.
